// File: rtl/apb_tx_pkg.sv
// Shared register map, status/control bit positions and APB phase encoding
// for the APB transmit buffer.
package apb_tx_pkg;

  localparam logic [3:0] DATA_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;
  localparam logic [3:0] RSVD_OFS   = 4'hC;

  // Register selects as seen on paddr[3:2].
  localparam logic [1:0] REG_DATA   = DATA_OFS[3:2];
  localparam logic [1:0] REG_STATUS = STATUS_OFS[3:2];
  localparam logic [1:0] REG_CTRL   = CTRL_OFS[3:2];

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_LEVEL_LSB = 8;
  localparam int ST_LEVEL_W   = 8;
  localparam int CTRL_FLUSH   = 0;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/dual_port_mem.sv
// Dual-port TX memory: port 1 writes, port 2 reads into a registered
// data_out that only changes when re is asserted.
module dual_port_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out <= '0;
    end else begin
      if (we) mem[addr1] <= data_in;
      if (re) data_out <= mem[addr2];
    end
  end

endmodule

// File: rtl/apb_tx_buffer.sv
// APB completer that pushes words into the TX memory and drains them in order
// onto a valid/ready stream through a one-word output register.
module apb_tx_buffer
  import apb_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Stream handshake: a word transfers on a cycle where tx_valid & tx_ready;
  // while tx_valid & ~tx_ready, tx_data holds steady.
  apb_state_e            state_q;
  apb_state_e            phase;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      mem_count;
  logic [CNT_W-1:0]      level;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] status_word;
  logic [1:0]            reg_sel;
  logic                  access;
  logic                  full;
  logic                  push;
  logic                  flush;
  logic                  fetch;
  logic                  unused_paddr;

  assign unused_paddr = &{1'b0, paddr[1:0]};

  // phase is the APB phase of the current bus cycle; state_q remembers the
  // previous one, so ACCESS lines up with the penable cycle (zero wait states).
  always_comb begin
    phase = APB_IDLE;
    if (reset) begin
      case (state_q)
        APB_IDLE:   phase = (psel && !penable) ? APB_SETUP : APB_IDLE;
        APB_SETUP:  phase = penable ? APB_ACCESS : (psel ? APB_SETUP : APB_IDLE);
        APB_ACCESS: phase = (psel && !penable) ? APB_SETUP : APB_IDLE;
        default:    phase = APB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= APB_IDLE;
    else        state_q <= phase;
  end

  assign access  = (phase == APB_ACCESS);
  assign reg_sel = paddr[3:2];
  assign full    = (mem_count == FULL_COUNT);
  assign level   = mem_count + CNT_W'(tx_valid);

  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY] = (level == '0);
    status_word[ST_FULL]  = full;
    status_word[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(level);
  end

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (reg_sel)
        REG_DATA:   pslverr = pwrite ? full : 1'b1;
        REG_STATUS: prdata  = pwrite ? '0 : status_word;
        REG_CTRL:   prdata  = '0;
        default:    pslverr = 1'b1;
      endcase
    end
  end

  assign pready = access;
  assign push   = access && pwrite && (reg_sel == REG_DATA) && !full;
  assign flush  = access && pwrite && (reg_sel == REG_CTRL) && pwdata[CTRL_FLUSH];

  // Start-of-cycle count gates the fetch, so a word pushed this cycle is
  // never read back in the same cycle.
  assign fetch  = (mem_count != '0) && (!tx_valid || tx_ready) && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      tx_valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      tx_valid  <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + CNT_W'(push) - CNT_W'(fetch);
      if (fetch)         tx_valid <= 1'b1;
      else if (tx_ready) tx_valid <= 1'b0;
    end
  end

  assign tx_data = tx_valid ? mem_dout : '0;

  dual_port_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .we       (push),
    .addr1    (wr_ptr),
    .data_in  (pwdata),
    .re       (fetch),
    .addr2    (rd_ptr),
    .data_out (mem_dout)
  );

endmodule
